fcs_insert: RTL

Transmit-side counterpart of the per-port receive FCS checker. It takes frame bytes (destination MAC through payload, no FCS) from a crossbar output FIFO and pads runt frames to minimum length. It computes the IEEE 802.3 CRC-32, appends the 4-byte FCS, and drives the byte-wide tx_ctrl/tx_data PHY-side interface, which uses the same framing as rx_ctrl/data_in. It enforces the inter-frame gap and signals underrun.

---
 rtl/eth_pkg.sv | 30 +++
 rtl/crc32_d8_update.sv | 15 +
 rtl/fcs_insert.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet framing constants, transmit FSM state type and CRC-32 byte step.
// Latency: n/a (package).
// Backpressure: n/a (package).
package eth_pkg;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    localparam int          ETH_MIN_FRAME   = 60;
    localparam int          ETH_FCS_BYTES   = 4;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PAD,
        FCS,
        DROP,
        IFG
    } tx_state_t;

    // Reflected CRC-32 advanced by one byte, LSB of the byte first.
    function automatic logic [31:0] crc32_d8(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_d8_update.sv
// Combinational one-byte CRC-32 step, shared by transmit FCS insert and receive check.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller decides when to register the result.
module crc32_d8_update
    import eth_pkg::*;
(
    input  logic [31:0] crc_cur,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);

    // Next CRC value for the presented byte.
    assign crc_next = crc32_d8(crc_cur, data);

endmodule

// File: rtl/fcs_insert.sv
// Transmit FCS insert: pads runts, appends CRC-32, enforces inter-frame gap, flags underrun.
// Latency: accepted byte appears on tx_data one cycle later; FCS follows the last data/pad byte directly.
// Backpressure: in_ready low during PAD, FCS and IFG; in_valid low mid-frame is an underrun, not a stall.
module fcs_insert
    import eth_pkg::*;
#(
    parameter int   P_MIN_FRAME = ETH_MIN_FRAME,
    parameter logic P_PAD_EN    = 1'b1,
    parameter int   P_IFG       = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       in_ready,
    output logic       tx_ctrl,
    output logic [7:0] tx_data,
    output logic       tx_done,
    output logic       tx_underrun
);

    localparam logic [11:0] MIN_LEN  = 12'(P_MIN_FRAME);
    localparam logic [4:0]  IFG_LAST = 5'(P_IFG - 1);
    localparam logic [1:0]  FCS_LAST = 2'(ETH_FCS_BYTES - 1);

    tx_state_t   state;
    logic [31:0] crc;
    logic [31:0] crc_seed;
    logic [31:0] crc_next;
    logic [7:0]  crc_byte;
    logic [10:0] byte_cnt;
    logic [10:0] cnt_inc;
    logic [11:0] cnt_plus1;
    logic [1:0]  fcs_cnt;
    logic [4:0]  ifg_cnt;
    logic        fcs_bad;
    logic [31:0] fcs_word;

    // Widened count of the byte about to be emitted; never wraps, so pad decisions stay correct.
    assign cnt_plus1 = {1'b0, byte_cnt} + 12'd1;
    // Saturating count so very long frames never alias into the pad range.
    assign cnt_inc   = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;
    // First byte of a frame always starts from the init value.
    assign crc_seed  = (state == IDLE) ? CRC32_INIT : crc;
    assign crc_byte  = (state == PAD) ? 8'h00 : in_data;
    // An underrun frame carries the raw CRC so the far end sees a guaranteed bad FCS.
    assign fcs_word  = fcs_bad ? crc : ~crc;

    crc32_d8_update u_crc (
        .crc_cur  (crc_seed),
        .data     (crc_byte),
        .crc_next (crc_next)
    );

    // Transmit FSM with all PHY-side outputs and in_ready registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            crc         <= CRC32_INIT;
            byte_cnt    <= 11'd0;
            fcs_cnt     <= 2'd0;
            ifg_cnt     <= 5'd0;
            fcs_bad     <= 1'b0;
            in_ready    <= 1'b1;
            tx_ctrl     <= 1'b0;
            tx_data     <= 8'h00;
            tx_done     <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            // tx_ctrl is still high only in the first cycle after FCS, which is where done belongs.
            tx_done     <= tx_ctrl && ((state == IFG) || (state == DROP));
            tx_underrun <= 1'b0;
            tx_ctrl     <= 1'b0;
            case (state)
                IDLE, DATA: begin
                    if (in_valid) begin
                        tx_ctrl  <= 1'b1;
                        tx_data  <= in_data;
                        crc      <= crc_next;
                        byte_cnt <= cnt_inc;
                        if (in_last) begin
                            in_ready <= 1'b0;
                            fcs_cnt  <= 2'd0;
                            if (P_PAD_EN && (cnt_plus1 < MIN_LEN)) begin
                                state <= PAD;
                            end else begin
                                state <= FCS;
                            end
                        end else begin
                            state <= DATA;
                        end
                    end else if (state == DATA) begin
                        // Underrun: first (uninverted) FCS byte goes out now to keep tx_ctrl contiguous.
                        tx_underrun <= 1'b1;
                        tx_ctrl     <= 1'b1;
                        tx_data     <= crc[7:0];
                        fcs_bad     <= 1'b1;
                        fcs_cnt     <= 2'd1;
                        in_ready    <= 1'b0;
                        state       <= FCS;
                    end
                end
                PAD: begin
                    tx_ctrl  <= 1'b1;
                    tx_data  <= 8'h00;
                    crc      <= crc_next;
                    byte_cnt <= cnt_inc;
                    if (cnt_plus1 >= MIN_LEN) begin
                        fcs_cnt <= 2'd0;
                        state   <= FCS;
                    end
                end
                FCS: begin
                    tx_ctrl <= 1'b1;
                    tx_data <= fcs_word[{fcs_cnt, 3'b000} +: 8];
                    fcs_cnt <= fcs_cnt + 2'd1;
                    if (fcs_cnt == FCS_LAST) begin
                        if (fcs_bad) begin
                            in_ready <= 1'b1;
                            state    <= DROP;
                        end else begin
                            ifg_cnt <= 5'd0;
                            state   <= IFG;
                        end
                    end
                end
                DROP: begin
                    // The in_last cycle already counts as the first gap cycle.
                    if (in_valid && in_last) begin
                        in_ready <= 1'b0;
                        fcs_bad  <= 1'b0;
                        ifg_cnt  <= 5'd1;
                        state    <= IFG;
                    end
                end
                IFG: begin
                    byte_cnt <= 11'd0;
                    ifg_cnt  <= ifg_cnt + 5'd1;
                    if (ifg_cnt >= IFG_LAST) begin
                        in_ready <= 1'b1;
                        fcs_bad  <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
